// File: rtl/bus_pkg.sv
// Shared definitions for the load/store bus responder: RV32I funct3 codes
// for loads and stores, the responder state type and a legality helper.
package bus_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_e;

    // True when funct3 names a load (we = 0) or store (we = 1) we implement.
    function automatic logic func3_legal(input logic we, input logic [2:0] func3);
        if (we) begin
            return (func3 == SB) || (func3 == SH) || (func3 == SW);
        end
        return (func3 == LB) || (func3 == LH) || (func3 == LW) ||
               (func3 == LBU) || (func3 == LHU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-aligned bus data and the word RAM:
// builds the store byte mask and replicated write word, extracts and
// extends the load lane, and flags misaligned halfword/word accesses.
module mem_lane_align
    import bus_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_we,
    output logic [31:0] write_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Size is func3[1:0]; func3[2] selects zero-extension for loads.
    always_comb begin
        byte_we    = 4'b0000;
        write_word = store_data;
        load_data  = ram_word;
        misalign   = 1'b0;
        sel_byte   = ram_word[{addr_lo, 3'b000} +: 8];
        sel_half   = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
        case (func3[1:0])
            2'b00: begin
                byte_we    = 4'b0001 << addr_lo;
                write_word = {4{store_data[7:0]}};
                load_data  = func3[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                byte_we    = addr_lo[1] ? 4'b1100 : 4'b0011;
                write_word = {2{store_data[15:0]}};
                load_data  = func3[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
                misalign   = addr_lo[0];
            end
            2'b10: begin
                byte_we  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_ram_responder.sv
// Memory end of the CPU load/store bus: one request at a time, a fixed
// number of wait states, then a one-cycle ready pulse with registered,
// extended read data and an error flag. Owns the word-organised RAM.
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busSel,
    input  logic        busWe,
    input  logic [2:0]  busFunc3,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    bus_state_e state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  func3_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             req_we;
    logic [2:0]       req_func3;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      ram_word;
    logic [3:0]       byte_we;
    logic [31:0]      write_word;
    logic [31:0]      load_data;
    logic             misalign;
    logic             out_of_range;
    logic             req_err;
    logic             commit;

    // With no wait states the access completes on the accept edge, so the
    // live bus inputs are used in IDLE and the latched request otherwise.
    always_comb begin
        if (state == IDLE) begin
            req_addr  = busAddr;
            req_wdata = busWData;
            req_we    = busWe;
            req_func3 = busFunc3;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_we    = we_q;
            req_func3 = func3_q;
        end
    end

    assign word_idx     = req_addr[IDX_W+1:2];
    assign ram_word     = mem[word_idx];
    assign out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign req_err      = out_of_range | misalign | ~func3_legal(req_we, req_func3);
    assign commit       = ((state == IDLE) && busSel && (WAIT_CYCLES == 0)) ||
                          ((state == WAIT) && (wait_cnt == 4'd0));

    mem_lane_align u_align (
        .func3      (req_func3),
        .addr_lo    (req_addr[1:0]),
        .store_data (req_wdata),
        .ram_word   (ram_word),
        .byte_we    (byte_we),
        .write_word (write_word),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    // Request FSM and registered response; the response is formed on the
    // edge that enters RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            busReady <= 1'b0;
            busErr   <= 1'b0;
            busRData <= 32'd0;
        end else begin
            busReady <= 1'b0;
            if (commit) begin
                state    <= RESP;
                busReady <= 1'b1;
                busErr   <= req_err;
                busRData <= (req_err || req_we) ? 32'd0 : load_data;
            end
            case (state)
                IDLE: begin
                    if (busSel) begin
                        addr_q  <= busAddr;
                        wdata_q <= busWData;
                        we_q    <= busWe;
                        func3_q <= busFunc3;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-lane merged store; suppressed on error and when reset wins the edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_we[b]) begin
                    mem[word_idx][8*b +: 8] <= write_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: three instances with 0, 1 and 3 wait states
// share the bus inputs but have private busSel lines. A byte-array model of
// each RAM predicts error, read data and response timing for each access.
module tb_bus_ram_responder;
    import bus_pkg::*;

    localparam int DEPTH = 64;

    typedef struct packed {
        int          lat;
        int          nready;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] hold;
    } obs_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] wd;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic        bwe;
    logic [2:0]  bf3;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata [3];
    logic        rdy [3];
    logic        err [3];

    logic [7:0]  ref_mem [3][DEPTH*4];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    bus_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .busSel(sel[0]), .busWe(bwe), .busFunc3(bf3),
        .busAddr(baddr), .busWData(bwdata), .busRData(rdata[0]), .busReady(rdy[0]), .busErr(err[0]));
    bus_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .busSel(sel[1]), .busWe(bwe), .busFunc3(bf3),
        .busAddr(baddr), .busWData(bwdata), .busRData(rdata[1]), .busReady(rdy[1]), .busErr(err[1]));
    bus_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .busSel(sel[2]), .busWe(bwe), .busFunc3(bf3),
        .busAddr(baddr), .busWData(bwdata), .busRData(rdata[2]), .busReady(rdy[2]), .busErr(err[2]));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("lat=%0d pulses=%0d data=%h err=%b hold=%h",
                         x.lat, x.nready, x.rdata, x.err, x.hold);
    endfunction

    // Reference: access of 1/2/4 bytes, little-endian, on a byte array.
    function automatic obs_t model_txn(input int d, input logic w, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] wd);
        obs_t        e;
        int          n;
        logic        bad;
        logic [31:0] v;
        e.lat    = wc(d);
        e.nready = 1;
        e.rdata  = 32'd0;
        e.err    = 1'b0;
        n = 1 << f[1:0];
        if (w) bad = (f > 3'd2);
        else   bad = (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
        if ((a / 4) >= DEPTH) bad = 1'b1;
        if ((a % n) != 0)     bad = 1'b1;
        if (bad) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int i = 0; i < n; i++) ref_mem[d][a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][a + i];
            if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.rdata = v;
        end
        e.hold = e.rdata;
        return e;
    endfunction

    // Drives one request on instance d starting at a negedge; returns at the
    // negedge of the IDLE cycle after RESP, the earliest next-request slot.
    task automatic run_txn(input int d, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        o.lat = -1; o.nready = 0; o.rdata = 32'd0; o.err = 1'b0; o.hold = 32'd0;
        bwe = w; bf3 = f; baddr = a; bwdata = wd; sel[d] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= wc(d) + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                sel[d] = 1'b0;
                bwe = 1'($urandom); bf3 = 3'($urandom); baddr = $urandom; bwdata = $urandom;
            end
            if (rdy[d]) begin
                if (o.lat < 0) begin
                    o.lat = c; o.rdata = rdata[d]; o.err = err[d];
                end
                o.nready++;
            end
            o.hold = rdata[d];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 3'b000; bwe = 1'b0; bf3 = 3'd0; baddr = 32'd0; bwdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rdy[0], rdy[1], rdy[2], err[0], err[1], err[2]} !== 6'b0 ||
                rdata[0] !== 32'd0 || rdata[1] !== 32'd0 || rdata[2] !== 32'd0)
                $display("FAIL reset_idle[%0d]: rdy=%b%b%b err=%b%b%b data=%h/%h/%h, expected all zero",
                         c, rdy[0], rdy[1], rdy[2], err[0], err[1], err[2], rdata[0], rdata[1], rdata[2]);
            else n_pass++;
        end
    endtask

    task automatic test_word();
        op_t ops[2];
        obs_t o, e;
        ops = '{'{1'b1, SW, 32'h10, 32'h8765_4321}, '{1'b0, LW, 32'h10, 32'h0}};
        foreach (ops[i]) begin
            e = model_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd);
            run_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, o);
            n_checks++;
            if (o !== e) $display("FAIL word[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
        n_checks++;
        if (o.rdata !== 32'h8765_4321 || o.lat !== 1)
            $display("FAIL word_lw_value: got %h lat %0d, expected 87654321 lat 1", o.rdata, o.lat);
        else n_pass++;
    endtask

    task automatic test_byte();
        op_t ops[4];
        obs_t o, e;
        ops = '{'{1'b1, SB, 32'h13, 32'h0000_00AB}, '{1'b0, LB, 32'h13, 32'h0},
                '{1'b0, LBU, 32'h13, 32'h0}, '{1'b0, LW, 32'h10, 32'h0}};
        foreach (ops[i]) begin
            e = model_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd);
            run_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, o);
            n_checks++;
            if (o !== e) $display("FAIL byte[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_half();
        op_t ops[5];
        obs_t o, e;
        ops = '{'{1'b1, SW, 32'h14, 32'h1122_3344}, '{1'b1, SH, 32'h16, 32'h0000_80F0},
                '{1'b0, LH, 32'h16, 32'h0}, '{1'b0, LHU, 32'h16, 32'h0},
                '{1'b0, LW, 32'h14, 32'h0}};
        foreach (ops[i]) begin
            e = model_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd);
            run_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, o);
            n_checks++;
            if (o !== e) $display("FAIL half[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        op_t ops[9];
        obs_t o, e;
        ops = '{'{1'b1, SW, 32'h20, 32'hCAFE_1234}, '{1'b0, LW, 32'h11, 32'h0},
                '{1'b1, SH, 32'h21, 32'h0000_BEEF}, '{1'b0, LW, 32'(4*DEPTH), 32'h0},
                '{1'b1, 3'b011, 32'h20, 32'h5555_5555}, '{1'b0, 3'b011, 32'h20, 32'h0},
                '{1'b1, 3'b100, 32'h20, 32'h0000_0066}, '{1'b0, LW, 32'h20, 32'h0},
                '{1'b0, LW, 32'h10, 32'h0}};
        foreach (ops[i]) begin
            e = model_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd);
            run_txn(1, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, o);
            n_checks++;
            if (o !== e) $display("FAIL error[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    // Reset lands on the commit edge for the 1-wait instance and inside WAIT
    // for the 3-wait instance; neither may write or respond.
    task automatic test_reset_in_wait();
        obs_t o, e;
        int   nrdy;
        for (int d = 1; d <= 2; d++) begin
            e = model_txn(d, 1'b1, SW, 32'h20, 32'h0BAD_F00D + d);
            run_txn(d, 1'b1, SW, 32'h20, 32'h0BAD_F00D + d, o);
            n_checks++;
            if (o !== e) $display("FAIL rstwait_pre[%0d]: got %s, expected %s", d, fmt(o), fmt(e));
            else n_pass++;
            bwe = 1'b1; bf3 = SW; baddr = 32'h20; bwdata = 32'hDEAD_BEEF; sel[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sel[d] = 1'b0;
            reset  = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            nrdy  = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (rdy[d]) nrdy++;
            end
            n_checks++;
            if (nrdy !== 0 || rdata[d] !== 32'd0 || err[d] !== 1'b0)
                $display("FAIL rstwait_quiet[%0d]: pulses=%0d data=%h err=%b, expected 0 0 0",
                         d, nrdy, rdata[d], err[d]);
            else n_pass++;
            e = model_txn(d, 1'b0, LW, 32'h20, 32'h0);
            run_txn(d, 1'b0, LW, 32'h20, 32'h0, o);
            n_checks++;
            if (o !== e) $display("FAIL rstwait_read[%0d]: got %s, expected %s", d, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_wait0();
        op_t ops[6];
        obs_t o, e;
        ops = '{'{1'b1, SW, 32'h30, 32'h1357_9BDF}, '{1'b0, LW, 32'h30, 32'h0},
                '{1'b1, SB, 32'h31, 32'h0000_0080}, '{1'b0, LB, 32'h31, 32'h0},
                '{1'b0, LHU, 32'h32, 32'h0}, '{1'b0, LH, 32'h30, 32'h0}};
        foreach (ops[i]) begin
            e = model_txn(0, ops[i].we, ops[i].f, ops[i].a, ops[i].wd);
            run_txn(0, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, o);
            n_checks++;
            if (o !== e) $display("FAIL wait0[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    // busSel held high: a new access starts every WAIT_CYCLES+2 cycles and
    // a request present on the edge leaving RESP is not taken.
    task automatic test_back_to_back();
        obs_t        e;
        logic [11:0] got, want;
        int          bad_data;
        e = model_txn(1, 1'b0, LW, 32'h10, 32'h0);
        bwe = 1'b0; bf3 = LW; baddr = 32'h10; bwdata = 32'h0; sel[1] = 1'b1;
        got = '0; want = '0; bad_data = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            got[c]  = rdy[1];
            want[c] = ((c % (wc(1) + 2)) == wc(1));
            if (rdy[1] && (rdata[1] !== e.rdata || err[1] !== 1'b0)) bad_data++;
        end
        sel[1] = 1'b0;
        n_checks++;
        if (got !== want || bad_data != 0)
            $display("FAIL back_to_back: ready pattern %b with %0d bad responses, expected %b with 0",
                     got, bad_data, want);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o, e;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a, wd;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) begin
                wd = $urandom;
                e = model_txn(d, 1'b1, SW, 32'(4*k), wd);
                run_txn(d, 1'b1, SW, 32'(4*k), wd, o);
                n_checks++;
                if (o !== e) $display("FAIL rand_fill[%0d.%0d]: got %s, expected %s", d, k, fmt(o), fmt(e));
                else n_pass++;
            end
            for (int k = 0; k < 40; k++) begin
                w  = 1'($urandom_range(0, 1));
                f  = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                     (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
                if (!w && f == 3'd3) f = LHU;
                a  = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + $urandom_range(0, 1023)
                                                 : 32'($urandom_range(0, 63));
                wd = $urandom;
                e = model_txn(d, w, f, a, wd);
                run_txn(d, w, f, a, wd, o);
                n_checks++;
                if (o !== e)
                    $display("FAIL rand[%0d.%0d] we=%b f3=%0d addr=%h: got %s, expected %s",
                             d, k, w, f, a, fmt(o), fmt(e));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_in_wait();
        test_wait0();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
